// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FIFO state encoding, default widths and the per-entry flag bundle
package addsub_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
    logic err;
  } flags_t;
endpackage

// File: rtl/addsub_flag_gen.sv
// addsub_flag_gen: combinational flags (c,v,z,n) and sum-mismatch check; in a,b,sub,s,cout -> out flags
module addsub_flag_gen
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  output flags_t           flags
);
  logic [WIDTH-1:0] eb;
  logic [WIDTH:0]   exp_sum;
  assign eb      = b ^ {WIDTH{sub}};
  assign exp_sum = {1'b0, a} + {1'b0, eb} + (WIDTH+1)'(sub);
  assign flags.c   = cout;
  assign flags.v   = (a[WIDTH-1] == eb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  assign flags.z   = s == '0;
  assign flags.n   = s[WIDTH-1];
  assign flags.err = {cout, s} != exp_sum;
endmodule

// File: rtl/addsub_result_stage.sv
// addsub_result_stage: 2-entry result FIFO with flags and saturating error count; in_* push side, out_* pop side, err_clr/err_cnt
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);
  state_t           state;
  flags_t           in_f, head_f, skid_f;
  logic [WIDTH-1:0] head_s, skid_s;
  logic             push, pop, mism;
  addsub_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .a(in_a), .b(in_b), .sub(in_sub), .s(in_s), .cout(in_cout), .flags(in_f)
  );
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign mism      = push && in_f.err;
  assign out_s     = head_s;
  assign {out_c, out_v, out_z, out_n, out_err} = head_f;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      head_s <= '0;
      head_f <= '0;
      skid_s <= '0;
      skid_f <= '0;
    end else begin
      case (state)
        EMPTY:   if (push) state <= ONE;
        ONE:     state <= (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
        FULL:    if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
      if (push && (state == EMPTY || pop)) begin
        head_s <= in_s;
        head_f <= in_f;
      end else if (pop && state == FULL) begin
        head_s <= skid_s;
        head_f <= skid_f;
      end
      if (push && state == ONE && !pop) begin
        skid_s <= in_s;
        skid_f <= in_f;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (err_clr) err_cnt <= CNT_W'(mism);
    else if (mism && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: directed and randomized checks against a queue-based reference model
module tb_addsub_result_stage;
  typedef logic [8:0] ent_t;
  logic       clk = 0, rst_n = 0;
  logic       in_valid, in_ready, in_sub, in_cout, out_valid, out_ready;
  logic [3:0] in_a, in_b, in_s, out_s;
  logic       out_c, out_v, out_z, out_n, out_err, err_clr;
  logic [7:0] err_cnt;
  int         passed = 0, total = 0, mcnt = 0;
  ent_t       q[$];
  addsub_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_s(in_s), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_c(out_c),
    .out_v(out_v), .out_z(out_z), .out_n(out_n), .out_err(out_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask
  function automatic int correct(int a, int b, int sub);
    return a + (sub != 0 ? (~b & 15) : b) + sub;
  endfunction
  function automatic ent_t model(int a, int b, int sub, int s, int cout);
    int eff, sum, sa, se, r;
    logic v;
    eff = sub != 0 ? (~b & 15) : b;
    sum = a + eff + sub;
    sa  = a > 7 ? a - 16 : a;
    se  = eff > 7 ? eff - 16 : eff;
    r   = sa + se + sub;
    v   = (s == (sum & 15)) ? (r > 7 || r < -8) : ((a >> 3) == (eff >> 3) && (s >> 3) != (a >> 3));
    return {4'(s), cout[0], v, s == 0, 1'(s >> 3), (cout * 16 + s) != sum};
  endfunction
  task automatic set_in(int v, int a, int b, int sub, int s, int cout);
    in_valid = v[0];
    in_a = 4'(a);
    in_b = 4'(b);
    in_sub = sub[0];
    in_s = 4'(s);
    in_cout = cout[0];
  endtask
  task automatic set_good(int a, int b, int sub);
    int c;
    c = correct(a, b, sub);
    set_in(1, a, b, sub, c & 15, c >> 4);
  endtask
  task automatic set_bad(int a, int b, int sub);
    int c;
    c = correct(a, b, sub);
    set_in(1, a, b, sub, (c + 1) & 15, c >> 4);
  endtask
  task automatic tick(output bit pushed);
    bit   pop, m;
    ent_t e;
    pushed = in_valid && q.size() < 2;
    pop    = q.size() != 0 && out_ready;
    if (pop) begin
      chk("pop_data", {out_s, out_c, out_v, out_z, out_n, out_err}, q[0]);
      void'(q.pop_front());
    end
    e = model(in_a, in_b, in_sub, in_s, in_cout);
    if (pushed) q.push_back(e);
    m = pushed && e[0];
    mcnt = err_clr ? int'(m) : (m ? (mcnt < 255 ? mcnt + 1 : 255) : mcnt);
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("err_cnt", err_cnt, mcnt);
  endtask
  task automatic t1();
    bit p;
    tick(p);
  endtask
  initial begin
    bit p;
    int n;
    set_in(0, 0, 0, 0, 0, 0);
    out_ready = 0;
    err_clr = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_outs", {out_s, out_c, out_v, out_z, out_n, out_err}, 0);
    rst_n = 1;
    out_ready = 1;
    set_good(7, 1, 0);
    t1();
    chk("add_7_1", {out_s, out_c, out_v, out_z, out_n, out_err}, 9'b1000_0_1_0_1_0);
    set_good(5, 5, 1);
    t1();
    chk("sub_5_5", {out_s, out_c, out_v, out_z, out_n, out_err}, 9'b0000_1_0_1_0_0);
    chk("sub_5_5_cnt", err_cnt, 0);
    in_valid = 0;
    t1();
    out_ready = 0;
    set_good(10, 1, 0);
    t1();
    set_good(2, 3, 0);
    t1();
    chk("bp_in_ready_low", in_ready, 0);
    set_good(4, 4, 0);
    t1();
    chk("bp_stable_1", out_s, 11);
    t1();
    chk("bp_stable_2", out_s, 11);
    out_ready = 1;
    n = 0;
    do begin tick(p); n++; end while (!p && n < 8);
    chk("bp_third_accepted", p, 1);
    in_valid = 0;
    n = 0;
    while (q.size() != 0 && n < 8) begin t1(); n++; end
    chk("bp_drained", out_valid, 0);
    set_in(1, 3, 2, 0, 4, 0);
    t1();
    chk("mm_err", out_err, 1);
    chk("mm_cnt", err_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      set_bad($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      t1();
    end
    chk("mm_saturated", err_cnt, 255);
    err_clr = 1;
    set_bad(6, 9, 1);
    t1();
    chk("clr_with_mm", err_cnt, 1);
    in_valid = 0;
    t1();
    chk("clr_plain", err_cnt, 0);
    err_clr = 0;
    t1();
    t1();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) set_bad($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      else set_good($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) in_cout = ~in_cout;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      err_clr = $urandom_range(0, 31) == 0;
      t1();
    end
    err_clr = 0;
    in_valid = 0;
    out_ready = 1;
    t1();
    t1();
    for (int i = 0; i < 512; i++) begin
      set_good(i & 15, (i >> 4) & 15, i >> 8);
      t1();
    end
    in_valid = 0;
    t1();
    t1();
    out_ready = 0;
    set_bad(1, 1, 0);
    t1();
    set_good(2, 2, 0);
    t1();
    chk("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_outs", {out_s, out_c, out_v, out_z, out_n, out_err}, 0);
    q.delete();
    mcnt = 0;
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    t1();
    t1();
    t1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
